// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: op encodings, FSM states, byte-enable
// patterns, and small decode helpers used by the FSM and the lane aligner.
package mem_access_stage_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Codes 9-15 fall into SZ_NONE, so they behave exactly like OP_NONE.
    function automatic size_e op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            OP_LW, OP_SW:         return SZ_WORD;
            default:              return SZ_NONE;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] offset);
        case (op_size(op))
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_data_align.sv
// Combinational lane logic: byte enables and store-data replication on the way
// out, lane extraction with sign/zero extension on the way back.
module mem_data_align
    import mem_access_stage_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rdata[7:0];
        half_sel  = offset[1] ? rdata[31:16] : rdata[15:0];
        be        = 4'b0000;
        wdata     = '0;
        load_data = '0;

        case (offset)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase

        case (op_size(op))
            SZ_BYTE: be = BE_BYTE0 << offset;
            SZ_HALF: be = offset[1] ? BE_HI_HALF : BE_LO_HALF;
            SZ_WORD: be = BE_WORD;
            default: be = 4'b0000;
        endcase

        // Loads leave wdata at zero; the memory ignores it when we=0.
        if (op_is_store(op)) begin
            case (op_size(op))
                SZ_BYTE: wdata = {4{store_data[7:0]}};
                SZ_HALF: wdata = {2{store_data[15:0]}};
                default: wdata = store_data;
            endcase
        end

        case (op)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'd0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'd0, half_sel};
            OP_LW:   load_data = rdata;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: accepts the ALU result, runs one req/ack data-memory
// access at a time with timeout, and produces the registered writeback.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10,
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [3:0]         i_mem_op,
    input  logic [NB_DATA-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_store_data,
    input  logic [4:0]         i_rd,
    output logic               o_busy,
    output logic               o_wb_valid,
    output logic [NB_DATA-1:0] o_wb_data,
    output logic [4:0]         o_wb_rd,
    output logic               o_misaligned,
    output logic               o_bus_error,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic [3:0]         o_mem_be,
    output logic [NB_DATA-1:0] o_mem_wdata,
    input  logic               i_mem_ack,
    input  logic [NB_DATA-1:0] i_mem_rdata
);

    // Counter only needs to reach TIMEOUT-1: the last waiting cycle is the expiry.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state, next_state;
    logic [CW-1:0] cnt;
    logic [3:0]    op_q;
    logic [1:0]    off_q;
    logic [4:0]    rd_q;

    logic accept, passthru, misal, done, expire;

    logic [3:0]  sel_op;
    logic [1:0]  sel_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;

    // One aligner serves both directions: new op while idle, latched op in REQ.
    assign sel_op  = (state == ST_REQ) ? op_q  : i_mem_op;
    assign sel_off = (state == ST_REQ) ? off_q : i_addr[1:0];

    mem_data_align u_align (
        .op         (sel_op),
        .offset     (sel_off),
        .store_data (i_store_data),
        .rdata      (i_mem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load)
    );

    assign o_busy = (state == ST_REQ);

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        passthru   = 1'b0;
        misal      = 1'b0;
        done       = 1'b0;
        expire     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_valid) begin
                    if (op_size(i_mem_op) == SZ_NONE) begin
                        passthru = 1'b1;
                    end else if (op_misaligned(i_mem_op, i_addr[1:0])) begin
                        misal = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        next_state = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Ack takes priority over a simultaneous expiry.
                if (i_mem_ack) begin
                    done       = 1'b1;
                    next_state = ST_IDLE;
                end else if (TIMEOUT > 0 && cnt == CNT_LAST) begin
                    expire     = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt          <= '0;
            op_q         <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            o_wb_valid   <= 1'b0;
            o_wb_data    <= '0;
            o_wb_rd      <= '0;
            o_misaligned <= 1'b0;
            o_bus_error  <= 1'b0;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_be     <= '0;
            o_mem_wdata  <= '0;
        end else begin
            o_wb_valid   <= 1'b0;
            o_misaligned <= misal;
            o_bus_error  <= expire;

            if (passthru) begin
                o_wb_valid <= 1'b1;
                o_wb_data  <= i_addr;
                o_wb_rd    <= i_rd;
            end

            if (accept) begin
                op_q        <= i_mem_op;
                off_q       <= i_addr[1:0];
                rd_q        <= i_rd;
                cnt         <= '0;
                o_mem_req   <= 1'b1;
                o_mem_we    <= op_is_store(i_mem_op);
                o_mem_addr  <= i_addr[NB_ADDR+1:2];
                o_mem_be    <= al_be;
                o_mem_wdata <= al_wdata;
            end else if (state == ST_REQ) begin
                cnt <= cnt + 1'b1;
            end

            if (done) begin
                o_mem_req <= 1'b0;
                if (!op_is_store(op_q)) begin
                    o_wb_valid <= 1'b1;
                    o_wb_data  <= al_load;
                    o_wb_rd    <= rd_q;
                end
            end

            if (expire) o_mem_req <= 1'b0;
        end
    end

endmodule
